// File: rtl/spi_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_reader
// Brief    : Read-only SPI master. Free-running SCLK, frames one WORD_BITS
//            read per request on rd, presents the word on d with a level
//            d_ready flag that is released by dropping rd.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_reader #(
    parameter int SCLK_HALF = 25,   // clk cycles per SCLK half-period, >= 2
    parameter int WORD_BITS = 16    // bits per frame, width of d
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 SDO,
    input  logic                 rd,
    output logic                 SCLK,
    output logic                 CS,
    output logic                 d_ready,
    output logic [WORD_BITS-1:0] d
);

    localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    logic [DIV_W-1:0]     div_q;
    logic                 sclk_q;
    state_t               state_q;
    logic                 cs_q;
    logic [WORD_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     bit_q;
    logic                 gap_q;
    logic [WORD_BITS-1:0] d_q;
    logic                 d_ready_q;

    logic w_wrap;
    logic w_rise_evt;
    logic w_fall_evt;

    // Divider wrap marks an SCLK edge; the current SCLK level tells which one.
    assign w_wrap     = (div_q == DIV_LAST);
    assign w_rise_evt = w_wrap & ~sclk_q;
    assign w_fall_evt = w_wrap &  sclk_q;

    // Free-running SCLK divider; runs in every state since the consumer may use SCLK as its clock.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (w_wrap) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Frame sequencer: CS moves only on fall events so exactly WORD_BITS rises land inside CS low.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b1;
            shift_q   <= '0;
            bit_q     <= '0;
            gap_q     <= 1'b0;
            d_q       <= '0;
            d_ready_q <= 1'b0;
        end else begin
            // Dropping rd releases the word on the following clk edge.
            if (!rd) begin
                d_ready_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cs_q <= 1'b1;
                    // A held d_ready blocks new frames, so a steady rd yields one word.
                    if (w_fall_evt && rd && !d_ready_q) begin
                        cs_q    <= 1'b0;
                        bit_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_rise_evt) begin
                        shift_q <= {shift_q[WORD_BITS-2:0], SDO};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (w_fall_evt) begin
                        cs_q      <= 1'b1;
                        d_q       <= shift_q;
                        // rd already gone means the consumer abandoned this word.
                        d_ready_q <= rd;
                        gap_q     <= 1'b0;
                        state_q   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    // Two fall events keep CS high for a full SCLK period before re-arming.
                    if (w_fall_evt) begin
                        gap_q <= ~gap_q;
                        if (gap_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= 1'b1;
                end
            endcase
        end
    end

    assign SCLK    = sclk_q;
    assign CS      = cs_q;
    assign d       = d_q;
    assign d_ready = d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_word_reader
// Brief    : Scoreboard bench for spi_word_reader with a behavioural
//            mode-0 peripheral that shifts tx_word MSB first on SCLK falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_reader;

    localparam int SCLK_HALF = 25;
    localparam int WORD_BITS = 16;
    localparam int CLK_NS    = 10;

    logic                 clk;
    logic                 rst_l;
    logic                 SDO;
    logic                 rd;
    logic                 SCLK;
    logic                 CS;
    logic                 d_ready;
    logic [WORD_BITS-1:0] d;

    logic [WORD_BITS-1:0] tx_word;
    time                  last_cs_rise;

    typedef struct {
        logic [WORD_BITS-1:0] word;
        logic                 rdy;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    spi_word_reader #(
        .SCLK_HALF (SCLK_HALF),
        .WORD_BITS (WORD_BITS)
    ) u_dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .SDO     (SDO),
        .rd      (rd),
        .SCLK    (SCLK),
        .CS      (CS),
        .d_ready (d_ready),
        .d       (d)
    );

    initial clk = 1'b0;
    always #(CLK_NS/2) clk = ~clk;

    always @(posedge CS) last_cs_rise = $time;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // which: 0 = CS, 1 = d_ready
    task automatic wait_level(input int which, input logic val, input int budget, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (which == 0) hit = (CS === val);
            else            hit = (d_ready === val);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s actual=timeout required=level_%0b", name, val);
        end
    endtask

    task automatic wait_rises(input int n, input int budget, input string name);
        int   seen;
        logic prev;
        seen = 0;
        prev = SCLK;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (!prev && SCLK) seen++;
            prev = SCLK;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, seen, n);
        end
    endtask

    // Peripheral: MSB out just after CS falls, next bit after each SCLK fall.
    initial begin
        int idx;
        SDO = 1'b0;
        forever begin
            @(negedge CS);
            #1;
            idx = WORD_BITS - 1;
            SDO = tx_word[idx];
            while (idx > 0) begin
                @(negedge SCLK or posedge CS);
                if (CS) break;
                #1;
                idx--;
                SDO = tx_word[idx];
            end
        end
    end

    // Monitor: at each completed frame compare d, d_ready and rise count with the queue head.
    initial begin
        int   rises;
        exp_t e;
        forever begin
            @(negedge CS);
            rises = 0;
            forever begin
                @(posedge SCLK or posedge CS);
                if (CS) break;
                rises++;
            end
            @(negedge clk);
            if (rst_l !== 1'b1) continue;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%h required=none", d);
            end else begin
                e = exp_q.pop_front();
                check("frame_word",  32'(d),       32'(e.word));
                check("frame_ready", 32'(d_ready), 32'(e.rdy));
                check("frame_rises", 32'(rises),   32'(WORD_BITS));
            end
        end
    end

    initial begin
        int   n;
        logic cs_bad;
        logic d_bad;
        checks       = 0;
        errors       = 0;
        last_cs_rise = 0;
        rst_l        = 1'b0;
        rd           = 1'b1;
        tx_word      = 16'hA5C3;

        // Reset state with rd already requesting
        repeat (60) @(negedge clk);
        check("rst_sclk",    32'(SCLK),    32'd0);
        check("rst_cs",      32'(CS),      32'd1);
        check("rst_d",       32'(d),       32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);

        // Single read of 0xA5C3
        exp_q.push_back('{word: 16'hA5C3, rdy: 1'b1});
        rst_l = 1'b1;
        wait_rises(1, 200, "sclk_first_rise");
        n = 0;
        while (SCLK === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sclk_half_period", 32'(n), 32'(SCLK_HALF));
        wait_level(1, 1'b1, 3000, "wait_ready_a5c3");
        check("word_a5c3", 32'(d), 32'h0000A5C3);

        // Holding rd must not start another frame
        cs_bad = 1'b0;
        d_bad  = 1'b0;
        for (int i = 0; i < 10 * 2 * SCLK_HALF; i++) begin
            @(negedge clk);
            if (CS !== 1'b1) cs_bad = 1'b1;
            if (d !== 16'hA5C3 || d_ready !== 1'b1) d_bad = 1'b1;
        end
        check("hold_cs_high", 32'(cs_bad), 32'd0);
        check("hold_d_stable", 32'(d_bad), 32'd0);

        // Handshake release and second word
        rd = 1'b0;
        @(negedge clk);
        check("ready_clear_1clk", 32'(d_ready), 32'd0);
        tx_word = 16'h1234;
        exp_q.push_back('{word: 16'h1234, rdy: 1'b1});
        rd = 1'b1;
        wait_level(0, 1'b0, 500, "wait_cs_1234");
        check("gap_1234", 32'(($time - last_cs_rise) >= 2 * SCLK_HALF * CLK_NS), 32'd1);
        wait_level(1, 1'b1, 3000, "wait_ready_1234");

        // Reset after 7 bits aborts the frame
        rd = 1'b0;
        repeat (2) @(negedge clk);
        tx_word = 16'hBEEF;
        rd = 1'b1;
        wait_level(0, 1'b0, 500, "wait_cs_abort");
        wait_rises(7, 1000, "abort_rises");
        repeat (3) @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("abort_cs",      32'(CS),      32'd1);
        check("abort_d",       32'(d),       32'd0);
        check("abort_d_ready", 32'(d_ready), 32'd0);
        check("abort_sclk",    32'(SCLK),    32'd0);
        tx_word = 16'h8001;
        exp_q.push_back('{word: 16'h8001, rdy: 1'b1});
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        wait_level(1, 1'b1, 3000, "wait_ready_8001");

        // rd dropped after bit 5: word lands, d_ready stays low
        rd = 1'b0;
        repeat (2) @(negedge clk);
        tx_word = 16'h00FF;
        exp_q.push_back('{word: 16'h00FF, rdy: 1'b0});
        rd = 1'b1;
        wait_level(0, 1'b0, 500, "wait_cs_00ff");
        wait_rises(5, 1000, "drop_rises");
        repeat (3) @(negedge clk);
        rd = 1'b0;
        wait_level(0, 1'b1, 2000, "wait_cs_end_00ff");
        check("drop_ready_low", 32'(d_ready), 32'd0);

        // Immediate re-request right after CS rises must respect the CS-high gap
        tx_word = 16'h5A0F;
        exp_q.push_back('{word: 16'h5A0F, rdy: 1'b1});
        rd = 1'b1;
        wait_level(0, 1'b0, 1000, "wait_cs_5a0f");
        check("gap_5a0f", 32'(($time - last_cs_rise) >= 2 * SCLK_HALF * CLK_NS), 32'd1);
        wait_level(1, 1'b1, 3000, "wait_ready_5a0f");
        check("word_5a0f", 32'(d), 32'h00005A0F);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
